event_count_controller: RTL and testbench

Parametrised successor to the fixed 4-bit S/X/Z/G count controller. It is started by `start` and counts `x` events into a WIDTH-bit counter until a programmable terminal value is reached, then pulses `g`. It adds abort, auto-restart mode and a completion counter. It sits beside the datapath as the sequencing block that gates counting and flags completion.

---
 rtl/event_count_pkg.sv | 17 +
 rtl/event_count_controller_count_unit.sv | 29 ++
 rtl/event_count_controller.sv | 104 ++++++++++
 tb/tb_event_count_controller.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/event_count_pkg.sv
// Shared types and constants for the event count controller.
package event_count_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 16;

  function automatic bit width_ok(input int w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/event_count_controller_count_unit.sv
// Event counter with synchronous clear/enable and a terminal-count compare.
module count_unit
  import event_count_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] lim,
  output logic [WIDTH-1:0] q,
  output logic             tc
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= q + WIDTH'(1);
    end
  end

  // The FSM never enables past tc, so the increment cannot wrap.
  assign tc = (q == lim);

endmodule

// File: rtl/event_count_controller.sv
// Start/count/complete sequencer: counts x events up to a captured limit and pulses g.
module event_count_controller
  import event_count_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int DONE_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              x,
  input  logic [WIDTH-1:0]  limit,
  input  logic              mode,
  input  logic              abort,
  output logic [WIDTH-1:0]  q,
  output logic              g,
  output logic              busy,
  output logic [1:0]        state,
  output logic [DONE_W-1:0] done_cnt
);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("event_count_controller: WIDTH out of range 2..16");
  end

  state_t           state_r;
  state_t           state_nxt;
  logic [WIDTH-1:0] lim_r;
  logic             clr;
  logic             en;
  logic             load;
  logic             complete;
  logic             tc;

  count_unit #(.WIDTH(WIDTH)) u_count (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .en    (en),
    .lim   (lim_r),
    .q     (q),
    .tc    (tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      lim_r    <= '0;
      done_cnt <= '0;
    end else begin
      state_r <= state_nxt;
      if (load) begin
        lim_r <= limit;
      end
      if (complete) begin
        done_cnt <= done_cnt + DONE_W'(1);
      end
    end
  end

  // abort outranks every other input; the terminal compare outranks x.
  always_comb begin
    state_nxt = state_r;
    clr       = 1'b0;
    en        = 1'b0;
    load      = 1'b0;
    complete  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          clr       = 1'b1;
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (tc) begin
          state_nxt = DONE;
        end else if (x) begin
          en = 1'b1;
        end
      end
      DONE: begin
        complete = 1'b1;
        if (abort || !mode) begin
          state_nxt = IDLE;
        end else begin
          clr       = 1'b1;
          state_nxt = RUN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign state = state_r;
  assign g     = (state_r == DONE);
  assign busy  = (state_r == RUN) || (state_r == DONE);

  a_state_legal : assert property (@(posedge clk) disable iff (reset) state != 2'b11);

endmodule

// File: tb/tb_event_count_controller.sv
// Bench for event_count_controller: a 4-bit/8-bit-done instance and an 8-bit/2-bit-done instance share stimulus.
module tb_event_count_controller;

  typedef struct packed {
    logic [1:0]  st;
    logic [15:0] q;
    logic        g;
    logic        busy;
    logic [7:0]  done;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       x;
  logic       mode;
  logic       abort;
  logic [7:0] lim;
  logic [3:0] limit_a;

  logic [3:0] q_a;
  logic       g_a;
  logic       busy_a;
  logic [1:0] state_a;
  logic [7:0] done_a;

  logic [7:0] q_b;
  logic       g_b;
  logic       busy_b;
  logic [1:0] state_b;
  logic [1:0] done_b;

  assign limit_a = lim[3:0];

  event_count_controller #(.WIDTH(4), .DONE_W(8)) dut_a (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .x        (x),
    .limit    (limit_a),
    .mode     (mode),
    .abort    (abort),
    .q        (q_a),
    .g        (g_a),
    .busy     (busy_a),
    .state    (state_a),
    .done_cnt (done_a)
  );

  event_count_controller #(.WIDTH(8), .DONE_W(2)) dut_b (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .x        (x),
    .limit    (lim),
    .mode     (mode),
    .abort    (abort),
    .q        (q_b),
    .g        (g_b),
    .busy     (busy_b),
    .state    (state_b),
    .done_cnt (done_b)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    passes = 0;
  string cur_test = "";

  logic [1:0]  m_st   [2];
  logic [15:0] m_q    [2];
  logic [15:0] m_lim  [2];
  logic [7:0]  m_done [2];
  exp_t        sb [$];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i]   = 2'b00;
      m_q[i]    = '0;
      m_lim[i]  = '0;
      m_done[i] = '0;
    end
  endtask

  // Advance the reference model by one edge and queue the expected outputs.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      logic [15:0] wm;
      logic [7:0]  dm;
      exp_t        e;
      wm = (i == 0) ? 16'h000F : 16'h00FF;
      dm = (i == 0) ? 8'hFF : 8'h03;
      case (m_st[i])
        2'b00: if (start) begin
          m_q[i]   = '0;
          m_lim[i] = {8'd0, lim} & wm;
          m_st[i]  = 2'b01;
        end
        2'b01: begin
          if (abort) m_st[i] = 2'b00;
          else if (m_q[i] == m_lim[i]) m_st[i] = 2'b10;
          else if (x) m_q[i] = m_q[i] + 16'd1;
        end
        2'b10: begin
          m_done[i] = (m_done[i] + 8'd1) & dm;
          if (abort || !mode) begin
            m_st[i] = 2'b00;
          end else begin
            m_q[i]  = '0;
            m_st[i] = 2'b01;
          end
        end
        default: m_st[i] = 2'b00;
      endcase
      e.st   = m_st[i];
      e.q    = m_q[i];
      e.g    = (m_st[i] == 2'b10);
      e.busy = (m_st[i] != 2'b00);
      e.done = m_done[i];
      sb.push_back(e);
    end
  endtask

  task automatic step();
    exp_t e;
    exp_t a;
    model_edge();
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      e = sb.pop_front();
      if (i == 0) a = {state_a, 12'd0, q_a, g_a, busy_a, done_a};
      else        a = {state_b, 8'd0, q_b, g_b, busy_b, 6'd0, done_b};
      checks++;
      if (a !== e)
        $display("FAIL %s sb dut%0d: got state=%0d q=%0d g=%b busy=%b done=%0d, expected state=%0d q=%0d g=%b busy=%b done=%0d",
                 cur_test, i, a.st, a.q, a.g, a.busy, a.done, e.st, e.q, e.g, e.busy, e.done);
      else passes++;
    end
  endtask

  task automatic test_reset();
    cur_test = "reset";
    reset = 1'b1; start = 1'b0; x = 1'b0; mode = 1'b0; abort = 1'b0; lim = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({state_a, q_a, g_a, busy_a, done_a} !== 16'd0)
      $display("FAIL reset dut_a outputs: got %h expected 0", {state_a, q_a, g_a, busy_a, done_a});
    else passes++;
    checks++;
    if ({state_b, q_b, g_b, busy_b, done_b} !== 14'd0)
      $display("FAIL reset dut_b outputs: got %h expected 0", {state_b, q_b, g_b, busy_b, done_b});
    else passes++;
    reset = 1'b0;
    model_reset();
    step();
  endtask

  task automatic test_one_shot();
    int n;
    cur_test = "one_shot";
    lim = 8'd5; mode = 1'b0; x = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (!g_a && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (n !== 6) $display("FAIL one_shot g latency: got %0d edges expected 6", n);
    else passes++;
    step();
    checks++;
    if ({state_a, q_a, done_a} !== {2'b00, 4'd5, 8'd1})
      $display("FAIL one_shot end: got state=%0d q=%0d done=%0d expected 0/5/1", state_a, q_a, done_a);
    else passes++;
  endtask

  task automatic test_gapped();
    logic [5:0] pat;
    int         qexp [6];
    cur_test = "gapped";
    pat  = 6'b101001;
    qexp = '{1, 1, 1, 2, 2, 3};
    lim = 8'd3; x = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      x = pat[k];
      step();
      checks++;
      if (q_a !== 4'(qexp[k])) $display("FAIL gapped q[%0d]: got %0d expected %0d", k, q_a, qexp[k]);
      else passes++;
    end
    x = 1'b0;
    step();
    checks++;
    if (g_a !== 1'b1 || q_a !== 4'd3) $display("FAIL gapped g: got g=%b q=%0d expected g=1 q=3", g_a, q_a);
    else passes++;
    step();
  endtask

  task automatic test_zero_limit();
    cur_test = "zero_limit";
    lim = 8'd0; x = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    checks++;
    if ({g_a, q_a, g_b, q_b} !== {1'b1, 4'd0, 1'b1, 8'd0})
      $display("FAIL zero_limit g: got g_a=%b q_a=%0d g_b=%b q_b=%0d expected g=1 q=0", g_a, q_a, g_b, q_b);
    else passes++;
    step();
  endtask

  task automatic test_full_limit();
    int n;
    cur_test = "full_limit";
    lim = 8'd255; x = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (!g_b && n < 300) begin
      step();
      n++;
      if (g_a) begin
        checks++;
        if (q_a !== 4'd15) $display("FAIL full_limit dut_a q at g: got %0d expected 15", q_a);
        else passes++;
      end
    end
    checks++;
    if (n !== 256 || q_b !== 8'd255)
      $display("FAIL full_limit dut_b: got %0d edges q=%0d expected 256 edges q=255", n, q_b);
    else passes++;
    step();
  endtask

  task automatic test_auto_restart();
    int         gcount;
    int         last;
    logic [7:0] d0;
    logic [7:0] dd;
    cur_test = "auto_restart";
    lim = 8'd2; mode = 1'b1; x = 1'b1; start = 1'b1;
    d0 = done_a;
    step();
    start = 1'b0;
    gcount = 0;
    last = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (g_a) begin
        if (last >= 0) begin
          checks++;
          if (k - last !== 4) $display("FAIL auto_restart spacing: got %0d expected 4", k - last);
          else passes++;
        end
        last = k;
        gcount++;
      end
    end
    dd = done_a - d0;
    checks++;
    if (gcount !== 5 || dd !== 8'd5 || last !== 19)
      $display("FAIL auto_restart totals: got g=%0d done_delta=%0d last=%0d expected 5/5/19", gcount, dd, last);
    else passes++;
    mode = 1'b0; abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  task automatic test_abort();
    cur_test = "abort";
    lim = 8'd5; mode = 1'b0; x = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if ({state_a, q_a, g_a, busy_a} !== {2'b00, 4'd2, 1'b0, 1'b0})
      $display("FAIL abort: got state=%0d q=%0d g=%b busy=%b expected 0/2/0/0", state_a, q_a, g_a, busy_a);
    else passes++;
    repeat (3) step();
  endtask

  task automatic test_async_reset();
    cur_test = "async_reset";
    lim = 8'd5; x = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({state_a, q_a, g_a, busy_a, done_a, state_b, q_b, g_b, busy_b, done_b} !== 30'd0)
      $display("FAIL async_reset: got a=%h b=%h expected 0", {state_a, q_a, g_a, busy_a, done_a},
               {state_b, q_b, g_b, busy_b, done_b});
    else passes++;
    model_reset();
    #1;
    reset = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_ignored();
    int n;
    cur_test = "ignored";
    lim = 8'd4; x = 1'b1; mode = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    start = 1'b1; lim = 8'd1;
    step();
    step();
    start = 1'b0;
    n = 0;
    while (!g_a && n < 10) begin
      step();
      n++;
    end
    checks++;
    if (g_a !== 1'b1 || q_a !== 4'd4 || q_b !== 8'd4)
      $display("FAIL ignored: got g=%b q_a=%0d q_b=%0d expected g=1 q=4", g_a, q_a, q_b);
    else passes++;
    step();
  endtask

  task automatic test_back_to_back();
    cur_test = "back_to_back";
    #2;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    model_reset();
    lim = 8'd0; mode = 1'b0; x = 1'b0; start = 1'b1;
    repeat (15) step();
    start = 1'b0;
    checks++;
    if (done_b !== 2'd1 || done_a !== 8'd5)
      $display("FAIL back_to_back done: got a=%0d b=%0d expected a=5 b=1", done_a, done_b);
    else passes++;
    step();
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_gapped();
    test_zero_limit();
    test_full_limit();
    test_auto_restart();
    test_abort();
    test_async_reset();
    test_ignored();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
